rgb_pwm: RTL and testbench
==========================

// Module: rgb_pwm
// PURPOSE
//  Three-channel PWM generator for the RGB LED. Consumes the one-clock-wide
//  enable pulses from the prescaler (tick) and drives the red/green/blue pins.
//  Duty values arrive over a valid/ready handshake, are staged, and take effect
//  only at a PWM period boundary, so a colour change never produces a glitch.
// PARAMETERS
//  PWM_WIDTH  8  width of the duty values and the PWM counter; period = 2**PWM_WIDTH ticks
// PORTS
//  clock       in   1          system clock; all state updates on posedge
//  reset       in   1          synchronous, active-high reset
//  tick        in   1          count enable from the prescaler; sampled every clock
//  enable      in   1          1 = generate PWM, 0 = idle (pins off)
//  duty_r      in   PWM_WIDTH  red duty, in ticks high per period
//  duty_g      in   PWM_WIDTH  green duty
//  duty_b      in   PWM_WIDTH  blue duty
//  duty_valid  in   1          duty_r/g/b are valid this cycle
//  duty_ready  out  1          staging register is free (combinational: ~pending & ~reset)
//  red         out  1          red PWM output (registered)
//  green       out  1          green PWM output (registered)
//  blue        out  1          blue PWM output (registered)
//  period_end  out  1          one-clock pulse after each counter wrap (registered)
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, active_r/g/b=0, pend_r/g/b=0, pending=0;
//   red/green/blue/period_end=0. duty_ready is 0 while reset=1 and 1 on the
//   first cycle after reset is released.
//  FSM states: IDLE and RUN.
//   IDLE: cnt held at 0; the registered outputs go to 0. enable=1 -> RUN next clock.
//   RUN: enable=0 -> IDLE next clock; cnt is cleared to 0 in that same clock.
//  Counter (RUN only): on a clock with tick=1, cnt <= cnt+1.
//   Counting wraps from 2**PWM_WIDTH-1 to 0 (the wrap tick).
//   tick=0 holds cnt.
//  Handshake: a transfer occurs when duty_valid && duty_ready.
//   On a transfer: pend_* <= duty_*, and pending <= 1.
//   duty_valid while duty_ready=0 is ignored. The sender must hold its data.
//  Commit of pending to active:
//   In RUN: on the wrap tick, active_* <= pend_* and pending <= 0.
//   In IDLE: on the clock after pending=1, the same commit happens.
//   A commit and a new transfer never collide in the same clock, because
//   ready=0 whenever pending=1.
//  Transfer in the same clock as a wrap tick:
//   - This only happens when pending=0, so that wrap commits nothing.
//   - The new value is applied at the next wrap.
//  Outputs, one-clock latency:
//   red <= (state==RUN) && enable && (cnt < active_r). Green and blue likewise.
//   active=0 gives constant low.
//   active=2**PWM_WIDTH-1 gives high for all but 1 tick per period.
//  period_end <= (state==RUN) && tick && (cnt==2**PWM_WIDTH-1).
//   It is a single-clock pulse.
//  Compare is unsigned, PWM_WIDTH bits. There is no other arithmetic.
//  Reset mid-operation overrides everything:
//   - Any in-flight pending value is discarded.
//   - Outputs are 0 on the clock after reset is sampled high.
// TESTING (PWM_WIDTH=4, tick=1 every 4th clock unless stated)
//  1 Reset then idle: reset 2 clocks, enable=0, 50 clocks.
//    -> all pins 0, period_end 0, duty_ready 1.
//  2 Basic PWM: load r=4, g=0, b=15 in IDLE, then enable=1 for 3 periods.
//    -> per 16 ticks: red high 4 ticks, green never, blue 15 ticks.
//    -> period_end pulses once per 64 clocks.
//  3 Glitch-free update: in RUN with r=4, load r=10 at cnt=7.
//    -> duty_ready=0 until the wrap; the remainder of the period stays at 4.
//    -> the next period is high 10 ticks, and duty_ready returns to 1 after the wrap.
//  4 Backpressure: hold duty_valid=1 with r=2, then r=9 on consecutive periods.
//    -> exactly one transfer per wrap; no value lost or duplicated.
//  5 Transfer coincident with the wrap tick, r changes 3->12.
//    -> the period that starts at that wrap still uses 3; the following period uses 12.
//  6 enable=0 mid-period, then reset mid-period with a pending value.
//    -> pins 0 after one clock and cnt=0.
//    -> after reset: active=0 and pending discarded; duty_ready 0 during reset, 1 after.

Source files
------------

// File: rtl/rgb_pwm_if.sv
// Duty-value handshake between the colour source (master) and the PWM block (slave).
interface rgb_pwm_if #(
    parameter int PWM_WIDTH = 8
);
    logic [PWM_WIDTH-1:0] duty_r;
    logic [PWM_WIDTH-1:0] duty_g;
    logic [PWM_WIDTH-1:0] duty_b;
    logic                 duty_valid;
    logic                 duty_ready;

    modport master (
        output duty_r, duty_g, duty_b, duty_valid,
        input  duty_ready
    );

    modport slave (
        input  duty_r, duty_g, duty_b, duty_valid,
        output duty_ready
    );
endinterface

// File: rtl/rgb_pwm.sv
// Three-channel glitch-free PWM for the RGB LED. Duty values are staged through
// a valid/ready handshake and only take effect at a PWM period boundary.
module rgb_pwm #(
    parameter int PWM_WIDTH = 8
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     tick,
    input  logic     enable,
    rgb_pwm_if.slave duty_if,
    output logic     red,
    output logic     green,
    output logic     blue,
    output logic     period_end
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    localparam logic [PWM_WIDTH-1:0] CNT_MAX = '1;

    state_t                    state_q, state_d;
    logic [PWM_WIDTH-1:0]      cnt_q, cnt_d;
    logic [2:0][PWM_WIDTH-1:0] active_q, active_d;
    logic [2:0][PWM_WIDTH-1:0] pend_q, pend_d;
    logic                      pending_q, pending_d;
    logic [2:0]                pwm_q, pwm_d;
    logic                      period_end_q, period_end_d;

    logic                      ready;
    logic                      run;
    logic                      wrap;
    logic                      xfer;
    logic                      commit;
    logic [2:0][PWM_WIDTH-1:0] duty_in;

    assign duty_in            = {duty_if.duty_b, duty_if.duty_g, duty_if.duty_r};
    assign ready              = ~pending_q & ~reset;
    assign duty_if.duty_ready = ready;
    assign run                = (state_q == RUN);
    assign wrap               = run && tick && (cnt_q == CNT_MAX);
    assign xfer               = duty_if.duty_valid && ready;
    // With no period running there is no boundary to wait for, so idle commits at once.
    assign commit             = pending_q && (!run || wrap);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!run) begin
            cnt_d = '0;
            if (enable) state_d = RUN;
        end else if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (tick) begin
            cnt_d = cnt_q + PWM_WIDTH'(1);
        end
    end

    // Commit and transfer are mutually exclusive: ready is low whenever pending is set.
    always_comb begin
        active_d  = active_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        if (commit) begin
            active_d  = pend_q;
            pending_d = 1'b0;
        end
        if (xfer) begin
            pend_d    = duty_in;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < 3; i++) begin
            pwm_d[i] = run && enable && (cnt_q < active_q[i]);
        end
        period_end_d = wrap;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            active_q     <= '0;
            pend_q       <= '0;
            pending_q    <= 1'b0;
            pwm_q        <= '0;
            period_end_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pending_q    <= pending_d;
            pwm_q        <= pwm_d;
            period_end_q <= period_end_d;
        end
    end

    assign red        = pwm_q[0];
    assign green      = pwm_q[1];
    assign blue       = pwm_q[2];
    assign period_end = period_end_q;
endmodule

// File: tb/tb_rgb_pwm.sv
// Directed and randomized check of rgb_pwm (PWM_WIDTH=4) against a per-clock
// behavioural model of the PWM period, staging and commit rules.
module tb_rgb_pwm;
    localparam int W      = 4;
    localparam int PERIOD = 1 << W;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0;
    logic enable = 1'b0;
    logic red, green, blue, period_end;

    rgb_pwm_if #(.PWM_WIDTH(W)) dif ();

    rgb_pwm #(.PWM_WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .enable     (enable),
        .duty_if    (dif),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .period_end (period_end)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;
    int tdiv       = 0;
    bit rand_tick  = 0;
    int dut_xfers  = 0;

    // Reference model state
    bit m_run = 0;
    int m_cnt = 0;
    int m_act[3] = '{0, 0, 0};
    int m_pend[3] = '{0, 0, 0};
    bit m_pending = 0;
    bit m_o[3] = '{0, 0, 0};
    bit m_pe = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clock();
        bit nxt_o[3];
        bit wrap, xfer, commit;
        if (reset) begin
            m_run = 0; m_cnt = 0; m_pending = 0; m_pe = 0;
            for (int i = 0; i < 3; i++) begin
                m_act[i] = 0; m_pend[i] = 0; m_o[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) nxt_o[i] = m_run && enable && (m_cnt < m_act[i]);
            wrap   = m_run && tick && (m_cnt == PERIOD - 1);
            xfer   = dif.duty_valid && !m_pending;
            commit = m_pending && (!m_run || wrap);
            if (m_run) m_cnt = !enable ? 0 : (tick ? (m_cnt + 1) % PERIOD : m_cnt);
            if (commit) begin
                m_act = m_pend;
                m_pending = 0;
            end
            if (xfer) begin
                m_pend[0] = int'(dif.duty_r);
                m_pend[1] = int'(dif.duty_g);
                m_pend[2] = int'(dif.duty_b);
                m_pending = 1;
            end
            m_run = enable;
            m_o   = nxt_o;
            m_pe  = wrap;
        end
    endtask

    task automatic step();
        bit hs;
        tdiv = (tdiv + 1) % 4;
        tick = rand_tick ? ($urandom_range(0, 1) == 1) : (tdiv == 0);
        hs = dif.duty_valid && dif.duty_ready;
        @(posedge clock);
        #1;
        if (hs) dut_xfers++;
        model_clock();
        chk("red", red, m_o[0]);
        chk("green", green, m_o[1]);
        chk("blue", blue, m_o[2]);
        chk("period_end", period_end, m_pe);
        chk("duty_ready", dif.duty_ready, !m_pending && !reset);
    endtask

    task automatic load(input int r, input int g, input int b);
        dif.duty_r = W'(r); dif.duty_g = W'(g); dif.duty_b = W'(b);
        dif.duty_valid = 1'b1;
        step();
        dif.duty_valid = 1'b0;
    endtask

    task automatic wait_pe(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!m_pe && n < 300);
        chk({tag, "_wait_wrap"}, m_pe, 1);
    endtask

    task automatic wait_cnt(input string tag, input int c, input bit need_wrap_next);
        int n = 0;
        while (!(m_cnt == c && (!need_wrap_next || tdiv == 3) && !m_pending) && n < 300) begin
            step();
            n++;
        end
        chk({tag, "_wait_cnt"}, m_cnt, c);
    endtask

    task automatic window(input string tag, input int er, input int eg, input int eb);
        int nr = 0, ng = 0, nb = 0, npe = 0;
        for (int i = 0; i < 4 * PERIOD; i++) begin
            step();
            nr += int'(red); ng += int'(green); nb += int'(blue); npe += int'(period_end);
        end
        chk({tag, "_red_clks"}, nr, er);
        chk({tag, "_green_clks"}, ng, eg);
        chk({tag, "_blue_clks"}, nb, eb);
        chk({tag, "_period_end_pulses"}, npe, 1);
    endtask

    initial begin
        int base;
        dif.duty_r = '0; dif.duty_g = '0; dif.duty_b = '0; dif.duty_valid = 1'b0;

        // 1: reset then idle
        reset = 1'b1;
        step(); step();
        chk("rst_ready_low", dif.duty_ready, 0);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) step();
        chk("idle_pins", {red, green, blue, period_end}, 0);
        chk("idle_ready", dif.duty_ready, 1);

        // 2: basic PWM, r=4 g=0 b=15 loaded in idle
        load(4, 0, 15);
        step();
        enable = 1'b1;
        wait_pe("p2");
        window("p2a", 16, 0, 60);
        window("p2b", 16, 0, 60);

        // 3: glitch-free update to r=10 at cnt=7
        wait_cnt("p3", 7, 0);
        load(10, 0, 15);
        chk("p3_ready_after_load", dif.duty_ready, 0);
        begin
            int n = 0;
            do begin
                step();
                n++;
                if (!m_pe) chk("p3_ready_held", dif.duty_ready, 0);
            end while (!m_pe && n < 300);
        end
        chk("p3_ready_after_wrap", dif.duty_ready, 1);
        window("p3", 40, 0, 60);

        // 4: backpressure, valid held with r=2 then r=9
        base = dut_xfers;
        dif.duty_r = 4'd2; dif.duty_g = 4'd0; dif.duty_b = 4'd15;
        dif.duty_valid = 1'b1;
        step();
        dif.duty_r = 4'd9;
        wait_pe("p4");
        window("p4a", 8, 0, 60);
        dif.duty_valid = 1'b0;
        window("p4b", 36, 0, 60);
        chk("p4_transfers", dut_xfers - base, 2);

        // 5: transfer coincident with the wrap tick, 3 -> 12
        load(3, 0, 15);
        wait_pe("p5_load3");
        wait_cnt("p5", PERIOD - 1, 1);
        load(12, 0, 15);
        chk("p5_coincident_wrap", period_end, 1);
        chk("p5_pending_after_wrap", dif.duty_ready, 0);
        window("p5a", 12, 0, 60);
        window("p5b", 48, 0, 60);

        // 6: enable drop mid-period, then reset with a pending value
        wait_cnt("p6_en", 5, 0);
        chk("p6_red_before", red, 1);
        enable = 1'b0;
        step();
        chk("p6_pins_off", {red, green, blue}, 0);
        step(); step();
        enable = 1'b1;
        step();
        wait_cnt("p6_rst", 6, 0);
        load(7, 7, 7);
        chk("p6_pending", dif.duty_ready, 0);
        step(); step();
        reset = 1'b1;
        step();
        chk("p6_rst_pins", {red, green, blue, period_end}, 0);
        chk("p6_rst_ready", dif.duty_ready, 0);
        step();
        reset = 1'b0;
        step();
        chk("p6_ready_after_rst", dif.duty_ready, 1);
        wait_pe("p6");
        window("p6", 0, 0, 0);

        // 7: randomized traffic against the model
        rand_tick = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            reset = ($urandom_range(0, 499) == 0);
            dif.duty_valid = ($urandom_range(0, 3) == 0);
            dif.duty_r = W'($urandom_range(0, PERIOD - 1));
            dif.duty_g = W'($urandom_range(0, PERIOD - 1));
            dif.duty_b = W'($urandom_range(0, PERIOD - 1));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
